// File: rtl/entrada_digito_if.sv
// Button/switch inputs and digit-strobe outputs of the lock's input stage.
interface entrada_digito_if;
    logic       botao;
    logic [4:1] chaves;
    logic       insere;
    logic [4:1] numero;
    logic       invalido;
    logic [4:1] contagem;

    modport master (
        output botao, chaves,
        input  insere, numero, invalido, contagem
    );

    modport slave (
        input  botao, chaves,
        output insere, numero, invalido, contagem
    );
endinterface

// File: rtl/entrada_digito.sv
// Synchronises and debounces the insert button, validates the BCD switch digit
// and emits a one-cycle accept/reject strobe plus a saturating accept count.
module entrada_digito #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    entrada_digito_if.slave    bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIG_W = 4;

    localparam logic [1:0] FILTRA_SOLTA = 2'd0;
    localparam logic [1:0] OCIOSO       = 2'd1;
    localparam logic [1:0] FILTRA_PRESS = 2'd2;
    localparam logic [1:0] PRESSIONADO  = 2'd3;

    localparam logic [CNT_W-1:0] LIMITE     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] UM         = CNT_W'(1);
    localparam logic [DIG_W-1:0] MAX_DIGITO = DIG_W'(9);
    localparam logic [DIG_W-1:0] CONT_MAX   = DIG_W'(15);

    logic             botao_m, botao_s;
    logic [DIG_W-1:0] chaves_m, chaves_s;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             qualifica;

    logic             insere_q, insere_nx;
    logic             invalido_q, invalido_nx;
    logic [DIG_W-1:0] numero_q, numero_nx;
    logic [DIG_W-1:0] contagem_q, contagem_nx;

    // Two-flop synchronisers for the asynchronous button and switches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            botao_m  <= 1'b0;
            botao_s  <= 1'b0;
            chaves_m <= '0;
            chaves_s <= '0;
        end else begin
            botao_m  <= bus.botao;
            botao_s  <= botao_m;
            chaves_m <= bus.chaves;
            chaves_s <= chaves_m;
        end
    end

    // State, filter counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILTRA_SOLTA;
            cnt        <= '0;
            insere_q   <= 1'b0;
            invalido_q <= 1'b0;
            numero_q   <= '0;
            contagem_q <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            insere_q   <= insere_nx;
            invalido_q <= invalido_nx;
            numero_q   <= numero_nx;
            contagem_q <= contagem_nx;
        end
    end

    assign cnt_inc = cnt + UM;

    // Next state: release must be confirmed before a press can qualify
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        qualifica = 1'b0;

        case (state)
            FILTRA_SOLTA: begin
                if (botao_s) begin
                    state_nx = PRESSIONADO;
                    cnt_nx   = '0;
                end else if (cnt_inc >= LIMITE) begin
                    state_nx = OCIOSO;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt_inc;
                end
            end
            OCIOSO: begin
                if (botao_s) begin
                    if (LIMITE <= UM) begin
                        qualifica = 1'b1;
                        state_nx  = PRESSIONADO;
                        cnt_nx    = '0;
                    end else begin
                        state_nx  = FILTRA_PRESS;
                        cnt_nx    = UM;
                    end
                end
            end
            FILTRA_PRESS: begin
                if (!botao_s) begin
                    state_nx = OCIOSO;
                    cnt_nx   = '0;
                end else if (cnt_inc >= LIMITE) begin
                    qualifica = 1'b1;
                    state_nx  = PRESSIONADO;
                    cnt_nx    = '0;
                end else begin
                    cnt_nx    = cnt_inc;
                end
            end
            PRESSIONADO: begin
                if (!botao_s) begin
                    if (LIMITE <= UM) begin
                        state_nx = OCIOSO;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = FILTRA_SOLTA;
                        cnt_nx   = UM;
                    end
                end
            end
            default: begin
                state_nx = FILTRA_SOLTA;
                cnt_nx   = '0;
            end
        endcase
    end

    // Digit validation on the qualifying edge; count saturates at 15
    always_comb begin
        insere_nx   = 1'b0;
        invalido_nx = 1'b0;
        numero_nx   = numero_q;
        contagem_nx = contagem_q;

        if (qualifica) begin
            if (chaves_s <= MAX_DIGITO) begin
                insere_nx = 1'b1;
                numero_nx = chaves_s;
                if (contagem_q != CONT_MAX) begin
                    contagem_nx = contagem_q + DIG_W'(1);
                end
            end else begin
                invalido_nx = 1'b1;
            end
        end
    end

    assign bus.insere   = insere_q;
    assign bus.invalido = invalido_q;
    assign bus.numero   = numero_q;
    assign bus.contagem = contagem_q;
endmodule

// File: tb/tb_entrada_digito.sv
// Bench for entrada_digito: directed scenarios plus random button/switch traffic,
// checked every cycle against a run-length model of the debounce behaviour.
module tb_entrada_digito;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic reset;

    entrada_digito_if bus ();

    entrada_digito #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n_ins       = 0;
    int n_inv       = 0;

    // Reference model: two-sample input delay, run lengths of equal samples,
    // and an "armed" flag set by a long enough release.
    logic        m_s1, m_s2;
    logic [3:0]  m_c1, m_c2;
    bit          armed;
    int unsigned ones, zeros;
    logic        exp_ins, exp_inv;
    logic [3:0]  exp_num, exp_cnt;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_c1 = 4'd0; m_c2 = 4'd0;
        armed = 1'b0; ones = 0; zeros = 0;
        exp_ins = 1'b0; exp_inv = 1'b0; exp_num = 4'd0; exp_cnt = 4'd0;
    endtask

    task automatic model_step();
        logic       b;
        logic [3:0] c;
        b = m_s2;
        c = m_c2;
        m_s2 = m_s1;
        m_c2 = m_c1;
        m_s1 = bus.botao;
        m_c1 = bus.chaves;
        exp_ins = 1'b0;
        exp_inv = 1'b0;
        if (b) begin
            ones++;
            zeros = 0;
        end else begin
            zeros++;
            ones = 0;
        end
        if (armed && ones == D) begin
            armed = 1'b0;
            if (c <= 4'd9) begin
                exp_ins = 1'b1;
                exp_num = c;
                exp_cnt = (exp_cnt == 4'd15) ? 4'd15 : exp_cnt + 4'd1;
            end else begin
                exp_inv = 1'b1;
            end
        end else if (!armed && zeros == D) begin
            armed = 1'b1;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    task automatic cycle_check();
        check("insere",   8'(bus.insere),   8'(exp_ins));
        check("invalido", 8'(bus.invalido), 8'(exp_inv));
        check("numero",   8'(bus.numero),   8'(exp_num));
        check("contagem", 8'(bus.contagem), 8'(exp_cnt));
        check("exclusive", 8'(bus.insere & bus.invalido), 8'd0);
        if (bus.insere === 1'b1)   n_ins++;
        if (bus.invalido === 1'b1) n_inv++;
    endtask

    task automatic drive(input logic b, input logic [3:0] c, input int n);
        bus.botao  = b;
        bus.chaves = c;
        repeat (n) begin
            @(negedge clk);
            cycle_check();
        end
    endtask

    int         base_ins, base_inv;
    logic [3:0] dig;
    logic       found;

    initial begin
        bus.botao  = 1'b0;
        bus.chaves = 4'd0;
        reset      = 1'b1;
        #2 reset   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cycle_check();
        end
        check("rst_insere",   8'(bus.insere),   8'd0);
        check("rst_invalido", 8'(bus.invalido), 8'd0);
        check("rst_numero",   8'(bus.numero),   8'd0);
        check("rst_contagem", 8'(bus.contagem), 8'd0);
        reset = 1'b1;
        drive(1'b0, 4'd0, 6);

        // Clean press of 5: strobe exactly after edge 6, then bouncy release
        base_ins = n_ins; base_inv = n_inv;
        bus.chaves = 4'd5;
        bus.botao  = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("t1_before_edge6", 8'(bus.insere), 8'd0);
        @(posedge clk);
        #1 check("t1_at_edge6", 8'(bus.insere), 8'd1);
        check("t1_numero_edge6", 8'(bus.numero), 8'd5);
        @(posedge clk);
        #1 check("t1_after_edge7", 8'(bus.insere), 8'd0);
        n_ins++;
        @(negedge clk);
        drive(1'b1, 4'd5, 3);
        drive(1'b0, 4'd5, 1);
        drive(1'b1, 4'd5, 1);
        drive(1'b0, 4'd5, 1);
        drive(1'b1, 4'd5, 1);
        drive(1'b0, 4'd5, 10);
        check("t1_pulses",   8'(n_ins - base_ins), 8'd1);
        check("t1_invalid",  8'(n_inv - base_inv), 8'd0);
        check("t1_numero",   8'(bus.numero),   8'd5);
        check("t1_contagem", 8'(bus.contagem), 8'd1);

        // Glitches too short to qualify
        base_ins = n_ins; base_inv = n_inv;
        drive(1'b1, 4'd7, 2);
        drive(1'b0, 4'd7, 3);
        drive(1'b1, 4'd7, 3);
        drive(1'b0, 4'd7, 8);
        check("t2_pulses",   8'(n_ins - base_ins), 8'd0);
        check("t2_invalid",  8'(n_inv - base_inv), 8'd0);
        check("t2_numero",   8'(bus.numero),   8'd5);
        check("t2_contagem", 8'(bus.contagem), 8'd1);

        // Clean press of 9
        base_ins = n_ins;
        drive(1'b1, 4'd9, 8);
        drive(1'b0, 4'd9, 8);
        check("t3_pulses",   8'(n_ins - base_ins), 8'd1);
        check("t3_numero",   8'(bus.numero),   8'd9);
        check("t3_contagem", 8'(bus.contagem), 8'd2);

        // Invalid digit 12
        base_ins = n_ins; base_inv = n_inv;
        drive(1'b1, 4'd12, 8);
        drive(1'b0, 4'd12, 8);
        check("t4_pulses",   8'(n_ins - base_ins), 8'd0);
        check("t4_invalid",  8'(n_inv - base_inv), 8'd1);
        check("t4_numero",   8'(bus.numero),   8'd9);
        check("t4_contagem", 8'(bus.contagem), 8'd2);

        // Button held through reset deassertion
        bus.botao = 1'b1;
        reset     = 1'b0;
        drive(1'b1, 4'd0, 2);
        reset = 1'b1;
        base_ins = n_ins; base_inv = n_inv;
        drive(1'b1, 4'd0, 20);
        check("t5_held_pulses",  8'(n_ins - base_ins), 8'd0);
        check("t5_held_invalid", 8'(n_inv - base_inv), 8'd0);
        check("t5_held_contagem", 8'(bus.contagem), 8'd0);
        drive(1'b0, 4'd0, 6);
        drive(1'b1, 4'd0, 8);
        drive(1'b0, 4'd0, 8);
        check("t5_pulses",   8'(n_ins - base_ins), 8'd1);
        check("t5_numero",   8'(bus.numero),   8'd0);
        check("t5_contagem", 8'(bus.contagem), 8'd1);

        // Random button levels and switch values
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  int'($urandom_range(1, 9)));
        end
        drive(1'b0, 4'd0, 8);

        // Saturation over 16 valid presses
        reset = 1'b0;
        drive(1'b0, 4'd0, 1);
        reset = 1'b1;
        drive(1'b0, 4'd0, 6);
        for (int i = 1; i <= 16; i++) begin
            dig = 4'($urandom_range(0, 9));
            drive(1'b1, dig, 7);
            drive(1'b0, dig, 8);
            check("sat_numero",   8'(bus.numero),   8'(dig));
            check("sat_contagem", 8'(bus.contagem), 8'((i < 15) ? i : 15));
        end

        // Asynchronous reset in the middle of a strobe
        bus.chaves = 4'd3;
        bus.botao  = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1 if (bus.insere === 1'b1) found = 1'b1;
        end
        check("arst_strobe_seen", 8'(found), 8'd1);
        reset = 1'b0;
        #1;
        check("arst_insere",   8'(bus.insere),   8'd0);
        check("arst_invalido", 8'(bus.invalido), 8'd0);
        check("arst_numero",   8'(bus.numero),   8'd0);
        check("arst_contagem", 8'(bus.contagem), 8'd0);
        @(negedge clk);
        bus.botao = 1'b0;
        reset     = 1'b1;
        drive(1'b0, 4'd0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
